// File: rtl/ad_pkg.sv
// Shared constants and sizing helpers for the ADC-code to millivolt converter.
package ad_pkg;

    // Offset-binary midscale: the code that maps to 0 mV.
    function automatic int midscale(input int ad_w);
        return 1 << (ad_w - 1);
    endfunction

    // |d| fits in ad_w bits and fs_mv in clog2+1 bits, so the product never overflows.
    function automatic int prod_w(input int ad_w, input int fs_mv);
        return ad_w + $clog2(fs_mv) + 1;
    endfunction

    // Symmetric saturation limit: the output range is +/- sat_max.
    function automatic int sat_max(input int volt_w);
        return (1 << (volt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/ad_avg_acc.sv
// One channel's window accumulator: sums converted samples, emits the floor mean
// and the OR of rail marks when the shared window counter flags the last sample.
module ad_avg_acc #(
    parameter int VOLT_W   = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     last,
    input  logic signed [VOLT_W-1:0] sample,
    input  logic                     rail,
    output logic [VOLT_W-1:0]        avg,
    output logic                     ovr
);
    localparam int AW = VOLT_W + AVG_LOG2;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic                 ovr_acc;

    assign sum = acc + AW'(sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovr_acc <= 1'b0;
            avg     <= '0;
            ovr     <= 1'b0;
        end else if (in_valid) begin
            if (last) begin
                // Arithmetic shift gives floor division for negative sums.
                avg     <= VOLT_W'(sum >>> AVG_LOG2);
                ovr     <= ovr_acc | rail;
                acc     <= '0;
                ovr_acc <= 1'b0;
            end else begin
                acc     <= sum;
                ovr_acc <= ovr_acc | rail;
            end
        end
    end

endmodule

// File: rtl/ad_volt_conv.sv
// Multi-channel offset-binary ADC code to signed millivolt converter, 3-stage pipeline.
// Define AD_VOLT_AVG_EN to add a 2^AVG_LOG2-sample averaging stage after conversion.
module ad_volt_conv
    import ad_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int AD_W     = 12,
    parameter int VOLT_W   = 16,
    parameter int FS_MV    = 10000,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  ad_clk,
    input  logic                  sys_rst_n,
    input  logic                  sample_en,
    input  logic [NCH*AD_W-1:0]   ad_in,
    output logic [NCH*VOLT_W-1:0] volt_out,
    output logic                  volt_valid,
    output logic [NCH-1:0]        ovr
);
    localparam int PW = prod_w(AD_W, FS_MV);
    localparam int CW = (PW > VOLT_W) ? PW : VOLT_W;
    localparam logic signed [AD_W:0] MID  = (AD_W+1)'(midscale(AD_W));
    localparam logic [CW-1:0]        VMAX = CW'(sat_max(VOLT_W));

    logic v1, v2;

    always_ff @(posedge ad_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= sample_en;
            v2 <= v1;
        end
    end

`ifdef AD_VOLT_AVG_EN
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic             v3;
    logic [CNT_W-1:0] win_cnt;
    logic             last;

    assign last = (win_cnt == LAST);

    // The window counter advances on converted samples, so reset drops any partial window.
    always_ff @(posedge ad_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v3         <= 1'b0;
            win_cnt    <= '0;
            volt_valid <= 1'b0;
        end else begin
            v3         <= v2;
            volt_valid <= v3 && last;
            if (v3) begin
                win_cnt <= last ? '0 : win_cnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge ad_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            volt_valid <= 1'b0;
        end else begin
            volt_valid <= v2;
        end
    end
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [AD_W-1:0]   code;
        logic signed [AD_W:0] d1;
        logic [AD_W-1:0]   abs_d;
        logic              rail1, rail2, neg2;
        logic [PW-1:0]     p2;
        logic [CW-1:0]     mag;
        logic [VOLT_W-1:0] mag_sat, v_next;

        assign code    = ad_in[k*AD_W +: AD_W];
        // |d| tops out at 2^(AD_W-1), which still fits in AD_W unsigned bits.
        assign abs_d   = AD_W'(d1[AD_W] ? -d1 : d1);
        assign mag     = CW'(p2 >> AD_W);
        assign mag_sat = (mag > VMAX) ? VOLT_W'(VMAX) : VOLT_W'(mag);
        assign v_next  = neg2 ? -mag_sat : mag_sat;

        always_ff @(posedge ad_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                d1    <= '0;
                rail1 <= 1'b0;
                p2    <= '0;
                neg2  <= 1'b0;
                rail2 <= 1'b0;
            end else begin
                if (sample_en) begin
                    d1    <= $signed({1'b0, code}) - MID;
                    rail1 <= (code == '0) || (code == '1);
                end
                if (v1) begin
                    p2    <= PW'(abs_d) * PW'(FS_MV);
                    neg2  <= d1[AD_W];
                    rail2 <= rail1;
                end
            end
        end

`ifdef AD_VOLT_AVG_EN
        logic signed [VOLT_W-1:0] v3_val;
        logic                     rail3;
        logic [VOLT_W-1:0]        avg;
        logic                     ch_ovr;

        always_ff @(posedge ad_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                v3_val <= '0;
                rail3  <= 1'b0;
            end else if (v2) begin
                v3_val <= v_next;
                rail3  <= rail2;
            end
        end

        ad_avg_acc #(
            .VOLT_W  (VOLT_W),
            .AVG_LOG2(AVG_LOG2)
        ) u_acc (
            .clk     (ad_clk),
            .rst_n   (sys_rst_n),
            .in_valid(v3),
            .last    (last),
            .sample  (v3_val),
            .rail    (rail3),
            .avg     (avg),
            .ovr     (ch_ovr)
        );

        assign volt_out[k*VOLT_W +: VOLT_W] = avg;
        assign ovr[k]                       = ch_ovr;
`else
        logic [VOLT_W-1:0] ch_volt;
        logic              ch_ovr;

        always_ff @(posedge ad_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                ch_volt <= '0;
                ch_ovr  <= 1'b0;
            end else if (v2) begin
                ch_volt <= v_next;
                ch_ovr  <= rail2;
            end
        end

        assign volt_out[k*VOLT_W +: VOLT_W] = ch_volt;
        assign ovr[k]                       = ch_ovr;
`endif
    end

endmodule

// File: doc/ad_volt_conv.md
AD_VOLT_CONV -- requirements
Module: ad_volt_conv

Interface
REQ-001 The block SHALL expose parameter NCH, default 2, number of ADC channels (1..8).
REQ-002 The block SHALL expose parameter AD_W, default 12, ADC code width (offset binary).
REQ-003 The block SHALL expose parameter VOLT_W, default 16, signed millivolt output width.
REQ-004 The block SHALL expose parameter FS_MV, default 10000, full-scale input span in mV.
REQ-005 The block SHALL expose parameter AVG_LOG2, default 2, log2 of the averaging window.
REQ-006 Port ad_clk, input, 1, sole clock.
REQ-007 Port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port sample_en, input, 1, ad_in holds a valid sample set this cycle.
REQ-009 Port ad_in, input, NCH*AD_W, channel k code at bits [k*AD_W +: AD_W].
REQ-010 Port volt_out, output, NCH*VOLT_W, signed mV, channel k at [k*VOLT_W +: VOLT_W].
REQ-011 Port volt_valid, output, 1, single-cycle pulse: volt_out updated.
REQ-012 Port ovr, output, NCH, per-channel rail flag for the current volt_out.

Function
REQ-013 Conversion SHALL compute d = code - 2^(AD_W-1) as signed AD_W+1 bits, then v = sign(d) * ((|d| * FS_MV) >> AD_W), i.e. magnitude truncation toward zero.
REQ-014 Intermediate product width SHALL be AD_W + clog2(FS_MV) + 1 bits, no overflow for any code.
REQ-015 v SHALL saturate to [-(2^(VOLT_W-1)-1), 2^(VOLT_W-1)-1] before output.
REQ-016 Pipeline: S1 register code and offset-subtract, S2 multiply, S3 shift/saturate; a per-stage valid bit tracks sample_en.
REQ-017 Gaps in sample_en SHALL be allowed; only valid samples advance the window counter; no backpressure exists.
REQ-018 A raw code equal to 0 or 2^AD_W-1 SHALL mark that channel as railed for the sample.
REQ-019 volt_out and ovr SHALL hold between volt_valid pulses.
REQ-020 All channels SHALL be processed in parallel in the same cycle.

Reset
REQ-021 On sys_rst_n low: volt_out=0, volt_valid=0, ovr=0, all stage valids, accumulators and window counter cleared.
REQ-022 Reset mid-window SHALL discard the partial sum; the first post-reset output requires a full fresh window.

Configuration
REQ-023 Macro AD_VOLT_AVG_EN SHALL compile in averaging: per-channel signed accumulator sums 2^AVG_LOG2 converted samples; on the last one output = sum >>> AVG_LOG2 (arithmetic, floor); ovr = OR of rail marks over the window; volt_valid pulses once per window, 4 cycles after the window's last sample_en.
REQ-024 Without AD_VOLT_AVG_EN, each sample SHALL produce an output with volt_valid 3 cycles after its sample_en, ovr from that sample only, and AVG_LOG2 ignored.

Structure
REQ-025 Package ad_pkg SHALL hold the offset-midscale function/constant, saturation limits and product-width function.
REQ-026 Sub-module ad_avg_acc SHALL implement one channel's accumulator, instantiated NCH times under AD_VOLT_AVG_EN; window counter shared in ad_volt_conv.

Verification
REQ-027 No averaging, ch0=0x800, ch1=0xFFF, one sample_en -> 3 cycles later volt_valid=1, ch0=0, ch1=+4997, ovr=2'b10.
REQ-028 No averaging, ch0=0x801, ch1=0x7FF -> ch0=+2, ch1=-2, ovr=0; ch0=0x000 -> -5000, ovr[0]=1.
REQ-029 Averaging AVG_LOG2=2, ch0 samples 0xFFF,0x800,0x800,0x800 -> single volt_valid, ch0=+1249, ovr[0]=1; ch0 -5000,0,0,0 equivalent codes -> -1250.
REQ-030 Averaging, sample_en with random 0-5 cycle gaps over 12 samples -> exactly 3 volt_valid pulses, values match model.
REQ-031 Averaging, reset asserted after 2 of 4 samples, then 4 samples of 0xC00 -> one pulse, ch=+2500, no stale contribution.
REQ-032 NCH=4, VOLT_W=12, FS_MV=20000, code 0xFFF -> saturates to +2047.
